// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, multi-cycle memory between the
// fetch (I) and memory-stage (D) ports. D has priority unless I has already
// lost STARVE_MAX grants in a row. Each access is launched with a one-cycle
// memEn pulse and finished by memReady. A busy state that never sees memReady
// within TIMEOUT cycles parks the block in ERR until reset.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 3,
    parameter int TIMEOUT    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iReq,
    input  logic [ADDR_W-1:0] iAddr,
    output logic [DATA_W-1:0] iData,
    output logic              iDone,
    output logic              iStall,
    input  logic              dReq,
    input  logic              dWr,
    input  logic [ADDR_W-1:0] dAddr,
    input  logic [DATA_W-1:0] dWData,
    output logic [DATA_W-1:0] dRData,
    output logic              dDone,
    output logic              dStall,
    output logic              memEn,
    output logic              memWr,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWData,
    input  logic [DATA_W-1:0] memRData,
    input  logic              memReady,
    output logic              err
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, ERR} stateT;

    stateT         state, stateNext;
    logic [SW-1:0] starve;
    logic [WW-1:0] waitCnt;
    logic          grantI, grantD, finish, timeOut;

    assign iStall = iReq & ~iDone;
    assign dStall = dReq & ~dDone;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= stateNext;
    end

    // Arbitration and busy-state sequencing. No grant is made while a done
    // pulse is out: the finishing requester still holds its req that cycle,
    // and this cycle is the mandatory turnaround between transactions.
    always_comb begin
        stateNext = state;
        grantI    = 1'b0;
        grantD    = 1'b0;
        finish    = 1'b0;
        timeOut   = 1'b0;
        case (state)
            IDLE: begin
                if (!(iDone || dDone)) begin
                    if (dReq && !(iReq && starve >= SW'(STARVE_MAX))) begin
                        grantD    = 1'b1;
                        stateNext = D_BUSY;
                    end else if (iReq) begin
                        grantI    = 1'b1;
                        stateNext = I_BUSY;
                    end
                end
            end
            I_BUSY, D_BUSY: begin
                // memReady takes precedence over a coincident timeout
                if (memReady) begin
                    finish    = 1'b1;
                    stateNext = IDLE;
                end else if (waitCnt == WW'(TIMEOUT - 1)) begin
                    timeOut   = 1'b1;
                    stateNext = ERR;
                end
            end
            ERR:     stateNext = ERR;
            default: stateNext = IDLE;
        endcase
    end

    // Memory command, returned data, done pulses and sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            memEn    <= 1'b0;
            memWr    <= 1'b0;
            memAddr  <= '0;
            memWData <= '0;
            iData    <= '0;
            dRData   <= '0;
            iDone    <= 1'b0;
            dDone    <= 1'b0;
            err      <= 1'b0;
        end else begin
            memEn <= grantI | grantD;
            iDone <= finish && (state == I_BUSY);
            dDone <= finish && (state == D_BUSY);
            if (grantD) begin
                memAddr  <= dAddr;
                memWData <= dWData;
                memWr    <= dWr;
            end else if (grantI) begin
                memAddr <= iAddr;
                memWr   <= 1'b0;
            end else if (finish) begin
                memWr <= 1'b0;
            end
            if (finish && state == I_BUSY)
                iData <= memRData;
            if (finish && state == D_BUSY && !memWr)
                dRData <= memRData;
            if (timeOut)
                err <= 1'b1;
        end
    end

    // Starvation count of D grants won while I waited, and busy-cycle timer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve  <= '0;
            waitCnt <= '0;
        end else begin
            if (grantD) begin
                if (!iReq)                          starve <= '0;
                else if (starve < SW'(STARVE_MAX))  starve <= starve + SW'(1);
            end else if (grantI) begin
                starve <= '0;
            end
            if (grantI || grantD)
                waitCnt <= '0;
            else if ((state == I_BUSY || state == D_BUSY) && !memReady && !timeOut)
                waitCnt <= waitCnt + WW'(1);
        end
    end

endmodule
